// File: rtl/system_reset_sequencer_pkg.sv
// Shared constants for the system reset sequencer: FSM state encodings,
// default timing parameters and the hold counter type.
package system_reset_sequencer_pkg;

  // Sequencer states; the numeric values are visible on seq_state.
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_WAIT = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } seq_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_RST_HOLD    = 16;
  localparam int DEF_EN_DELAY    = 8;

  // Hold/delay counter is 8 bits; both timing parameters are limited to 255.
  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] seq_cnt_t;

  // Counter value on which a timed state is left (a stay of 'cycles' clocks).
  function automatic seq_cnt_t terminal_count(input int cycles);
    return seq_cnt_t'(cycles - 1);
  endfunction

endpackage

// File: rtl/system_reset_sequencer_bit_sync.sv
// Multi-flop synchroniser for one asynchronous control bit. The chain is
// cleared by the block reset so a stale request cannot survive a reset.
module bit_sync
  import system_reset_sequencer_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/system_reset_sequencer.sv
// System reset sequencer: holds system_reset for RST_HOLD cycles after the
// last reset request, then waits EN_DELAY cycles before enabling the CPUs.
// The CPU enable from JTAG is followed directly once the sequence completes.
// Legal ranges: SYNC_STAGES 2..4, RST_HOLD 1..255, EN_DELAY 1..255.
module system_reset_sequencer
  import system_reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int RST_HOLD    = DEF_RST_HOLD,
  parameter int EN_DELAY    = DEF_EN_DELAY
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       jtag_system_reset,
  input  logic       jtag_cpu_en,
  input  logic       ext_reset,
  output logic       system_reset,
  output logic       cpu_en,
  output logic [1:0] seq_state
);

  localparam seq_cnt_t RST_TC = terminal_count(RST_HOLD);
  localparam seq_cnt_t EN_TC  = terminal_count(EN_DELAY);

  logic rst_s;
  logic ext_s;
  logic en_s;
  logic req;

  seq_state_t state;
  seq_state_t nxt_state;
  seq_cnt_t   cnt;
  seq_cnt_t   nxt_cnt;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rst (
    .clk   (clk),
    .reset (reset),
    .din   (jtag_system_reset),
    .dout  (rst_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk   (clk),
    .reset (reset),
    .din   (ext_reset),
    .dout  (ext_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk   (clk),
    .reset (reset),
    .din   (jtag_cpu_en),
    .dout  (en_s)
  );

  assign req = rst_s | ext_s;

  // Next-state and counter logic; any pending request restarts the hold.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    if (req) begin
      nxt_state = ST_RST;
      nxt_cnt   = '0;
    end else begin
      unique case (state)
        ST_RST: begin
          if (cnt == RST_TC) begin
            nxt_state = ST_WAIT;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + seq_cnt_t'(1);
          end
        end
        ST_WAIT: begin
          // The enable is only looked at on the final delay cycle.
          if (cnt == EN_TC) begin
            nxt_state = en_s ? ST_RUN : ST_HALT;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + seq_cnt_t'(1);
          end
        end
        ST_RUN: begin
          if (!en_s) nxt_state = ST_HALT;
        end
        ST_HALT: begin
          if (en_s) nxt_state = ST_RUN;
        end
        default: begin
          nxt_state = ST_RST;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // State, counter and outputs; outputs are registered from the next state
  // so they change on the same edge as seq_state and never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RST;
      cnt          <= '0;
      system_reset <= 1'b1;
      cpu_en       <= 1'b0;
    end else begin
      state        <= nxt_state;
      cnt          <= nxt_cnt;
      system_reset <= (nxt_state == ST_RST);
      cpu_en       <= (nxt_state == ST_RUN);
    end
  end

  assign seq_state = state;

endmodule

// File: tb/tb_system_reset_sequencer.sv
// Bench for system_reset_sequencer: two instances (default timing, and a
// short-timing variant) driven by the same directed and random stimulus and
// compared each cycle against a cycles-since-last-request model.
module tb_system_reset_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic jtag_system_reset;
  logic jtag_cpu_en;
  logic ext_reset;

  logic       sr0, ce0, sr1, ce1;
  logic [1:0] ss0, ss1;

  int n_err    = 0;
  int n_checks = 0;

  // Per-instance timing: instance 0 defaults, instance 1 short timing.
  int ns [2] = '{2, 3};
  int hd [2] = '{16, 1};
  int dl [2] = '{8, 1};

  // Model: delay lines for the synchronisers, and k = edges since the last
  // restart (block reset or synchronised request).
  bit qr [2][4];
  bit qe [2][4];
  bit qn [2][4];
  int k_m [2];
  int exp_st [2];

  always #5 clk = ~clk;

  system_reset_sequencer u_dut0 (
    .clk               (clk),
    .reset             (reset),
    .jtag_system_reset (jtag_system_reset),
    .jtag_cpu_en       (jtag_cpu_en),
    .ext_reset         (ext_reset),
    .system_reset      (sr0),
    .cpu_en            (ce0),
    .seq_state         (ss0)
  );

  system_reset_sequencer #(.SYNC_STAGES(3), .RST_HOLD(1), .EN_DELAY(1)) u_dut1 (
    .clk               (clk),
    .reset             (reset),
    .jtag_system_reset (jtag_system_reset),
    .jtag_cpu_en       (jtag_cpu_en),
    .ext_reset         (ext_reset),
    .system_reset      (sr1),
    .cpu_en            (ce1),
    .seq_state         (ss1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit rs, es, en;
      int n;
      n  = ns[i];
      rs = qr[i][n-1];
      es = qe[i][n-1];
      en = qn[i][n-1];
      if (reset) begin
        k_m[i] = 0;
        for (int j = 0; j < 4; j++) begin
          qr[i][j] = 1'b0;
          qe[i][j] = 1'b0;
          qn[i][j] = 1'b0;
        end
      end else begin
        if (rs || es) k_m[i] = 0;
        else if (k_m[i] < 100000) k_m[i] = k_m[i] + 1;
        for (int j = 3; j > 0; j--) begin
          qr[i][j] = qr[i][j-1];
          qe[i][j] = qe[i][j-1];
          qn[i][j] = qn[i][j-1];
        end
        qr[i][0] = jtag_system_reset;
        qe[i][0] = ext_reset;
        qn[i][0] = jtag_cpu_en;
      end
      if (k_m[i] < hd[i])              exp_st[i] = 0;
      else if (k_m[i] < hd[i] + dl[i]) exp_st[i] = 1;
      else                             exp_st[i] = en ? 2 : 3;
    end
  endtask

  task automatic check_all();
    chk("st0", 32'(ss0), 32'(exp_st[0]));
    chk("sr0", 32'(sr0), 32'(exp_st[0] == 0));
    chk("en0", 32'(ce0), 32'(exp_st[0] == 2));
    chk("st1", 32'(ss1), 32'(exp_st[1]));
    chk("sr1", 32'(sr1), 32'(exp_st[1] == 0));
    chk("en1", 32'(ce1), 32'(exp_st[1] == 2));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int edges;
    int hi_cnt;
    int first_en;

    reset             = 1'b1;
    jtag_system_reset = 1'b0;
    jtag_cpu_en       = 1'b1;
    ext_reset         = 1'b0;
    run(3);

    // Release from reset: hold length and enable time on the default instance.
    reset    = 1'b0;
    hi_cnt   = 1;
    first_en = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (sr0) hi_cnt++;
      if (ce0 && first_en < 0) first_en = c;
    end
    chk("hold_len", 32'(hi_cnt), 32'd16);
    chk("en_cycle", 32'(first_en), 32'd24);

    // Request pulse in RUN: latency to system_reset.
    jtag_system_reset = 1'b1;
    edges = 0;
    for (int c = 1; c <= 10 && !sr0; c++) begin
      step();
      edges = c;
      if (c == 5) jtag_system_reset = 1'b0;
    end
    chk("req_lat", 32'(edges), 32'd3);
    run(2);
    jtag_system_reset = 1'b0;
    run(40);

    // Drop and raise the CPU enable in RUN.
    jtag_cpu_en = 1'b0;
    edges = 0;
    for (int c = 1; c <= 10 && ss0 != 2'd3; c++) begin
      step();
      edges = c;
    end
    chk("halt_lat", 32'(edges), 32'd3);
    run(3);
    jtag_cpu_en = 1'b1;
    edges = 0;
    for (int c = 1; c <= 10 && !ce0; c++) begin
      step();
      edges = c;
    end
    chk("run_lat", 32'(edges), 32'd3);
    run(3);

    // Re-pulse ext_reset at count 10 of the hold.
    ext_reset = 1'b1;
    step();
    ext_reset = 1'b0;
    for (int c = 0; c < 60 && !(exp_st[0] == 0 && k_m[0] == 10 && c > 3); c++) step();
    chk("reach_cnt10", 32'(k_m[0]), 32'd10);
    ext_reset = 1'b1;
    step();
    ext_reset = 1'b0;
    run(40);

    // Block reset at count 4 of the wait.
    ext_reset = 1'b1;
    step();
    ext_reset = 1'b0;
    for (int c = 0; c < 60 && !(exp_st[0] == 1 && k_m[0] == 20); c++) step();
    chk("reach_wait4", 32'(exp_st[0] == 1 && k_m[0] == 20), 32'd1);
    reset = 1'b1;
    step();
    chk("rst_mid_sr", 32'(sr0), 32'd1);
    reset = 1'b0;
    run(40);

    // Enable low throughout; short-timing instance goes 0,1,3.
    jtag_cpu_en = 1'b0;
    ext_reset   = 1'b1;
    step();
    ext_reset = 1'b0;
    run(40);

    // Random stimulus.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 199) == 0) reset = 1'b1;
      else reset = 1'b0;
      if ($urandom_range(0, 59) == 0) jtag_system_reset = ~jtag_system_reset;
      if ($urandom_range(0, 59) == 0) ext_reset = ~ext_reset;
      if ($urandom_range(0, 29) == 0) jtag_cpu_en = ~jtag_cpu_en;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
